slow_ram_arbiter: RTL

//   Shares one slow_ram line port between two requesters: port 0 is instruction fetch, port 1 is data load/store.

---
 rtl/slow_ram_pkg.sv | 22 ++
 rtl/slow_ram_arb_pick.sv | 31 +++
 rtl/slow_ram_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/slow_ram_pkg.sv
// Shared types and constants for the slow_ram line-port arbiter.
// Build option SLOW_RAM_ARB_RR_EN selects round-robin instead of fixed priority.
package slow_ram_pkg;

    localparam int ADDRESS_WIDTH    = 20;
    localparam int DATA_WIDTH_SHIFT = 4;
    localparam int LW               = ADDRESS_WIDTH - DATA_WIDTH_SHIFT;
    localparam int DW               = (2 ** DATA_WIDTH_SHIFT) * 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int PORT_FETCH = 0;
    localparam int PORT_DATA  = 1;

    function automatic logic [1:0] port_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/slow_ram_arb_pick.sv
// Combinational 2-way grant: fixed priority (data port wins ties) by default,
// round-robin on ties when SLOW_RAM_ARB_RR_EN is defined.
module slow_ram_arb_pick
    import slow_ram_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

`ifdef SLOW_RAM_ARB_RR_EN
    // On a tie, the port that did not win last time takes the grant.
    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = last_i ? port_onehot(1'b0) : port_onehot(1'b1);
        end
    end
`else
    logic unused_last;
    assign unused_last = last_i;

    always_comb begin
        grant_o = valid_i;
        if (valid_i[PORT_DATA]) begin
            grant_o = port_onehot(1'b1);
        end
    end
`endif

endmodule

// File: rtl/slow_ram_arbiter.sv
// Shares one slow_ram line port between fetch (port 0) and data (port 1), one access at a time.
// Build option SLOW_RAM_ARB_RR_EN enables round-robin tie breaking.
module slow_ram_arbiter
    import slow_ram_pkg::*;
#(
    parameter  int ADDRESS_WIDTH    = 20,
    parameter  int DATA_WIDTH_SHIFT = 4,
    localparam int LW               = ADDRESS_WIDTH - DATA_WIDTH_SHIFT,
    localparam int DW               = (2 ** DATA_WIDTH_SHIFT) * 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [1:0]    req_valid_i,
    output logic [1:0]    req_ready_o,
    input  logic [LW-1:0] req0_addr_i,
    input  logic [LW-1:0] req1_addr_i,
    input  logic          req1_we_i,
    input  logic [DW-1:0] req1_wdata_i,
    output logic [1:0]    resp_valid_o,
    output logic [DW-1:0] resp_rdata_o,
    output logic [LW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_data_o,
    output logic          mem_we_o,
    output logic          mem_valid_o,
    input  logic [DW-1:0] mem_data_i,
    input  logic          mem_valid_i
);

    arb_state_e    state_q, state_d;
    logic [1:0]    grant;
    logic          last_sel;
    logic          accept;
    logic          complete;

    logic [LW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic          mem_we_q, mem_we_d;
    logic          grant_id_q, grant_id_d;
    logic [1:0]    resp_valid_q, resp_valid_d;
    logic [DW-1:0] resp_rdata_q, resp_rdata_d;

`ifdef SLOW_RAM_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = grant[PORT_DATA];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_sel = last_q;
`else
    assign last_sel = 1'b0;
`endif

    slow_ram_arb_pick u_pick (
        .valid_i (req_valid_i),
        .last_i  (last_sel),
        .grant_o (grant)
    );

    assign accept   = |req_ready_o;
    assign complete = (state_q == ARB_BUSY) & mem_valid_i;

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (accept)      state_d = ARB_BUSY;
            ARB_BUSY: if (mem_valid_i) state_d = ARB_IDLE;
            default:                   state_d = ARB_IDLE;
        endcase
    end

    // FSM: outputs. Valid drops while slow_ram reports done so it sees one access only.
    always_comb begin
        req_ready_o = 2'b00;
        mem_valid_o = 1'b0;
        case (state_q)
            ARB_IDLE: req_ready_o = grant;
            ARB_BUSY: mem_valid_o = ~mem_valid_i;
            default:  req_ready_o = 2'b00;
        endcase
    end

    // Request capture on accept; held constant for the whole access.
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = mem_we_q;
        grant_id_d = grant_id_q;
        if (accept) begin
            grant_id_d = grant[PORT_DATA];
            if (grant[PORT_DATA]) begin
                mem_addr_d = req1_addr_i;
                mem_data_d = req1_wdata_i;
                mem_we_d   = req1_we_i;
            end else begin
                mem_addr_d = req0_addr_i;
                mem_data_d = '0;
                mem_we_d   = 1'b0;
            end
        end
    end

    always_comb begin
        resp_valid_d = 2'b00;
        resp_rdata_d = resp_rdata_q;
        if (complete) begin
            resp_valid_d = port_onehot(grant_id_q);
            resp_rdata_d = mem_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            grant_id_q   <= 1'b0;
            resp_valid_q <= 2'b00;
            resp_rdata_q <= '0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            grant_id_q   <= grant_id_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign mem_we_o     = mem_we_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;

endmodule
